// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event generator and its millisecond tick source.
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    localparam int unsigned HOLD_W   = 16;
    localparam int unsigned MS_PER_S = 1000;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
        return (v == '1) ? v : v + HOLD_W'(1);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running divider producing a registered 1-cycle strobe once per millisecond.
module ms_tick_gen
    import key_event_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV   = (CLK_HZ / MS_PER_S > 1) ? CLK_HZ / MS_PER_S : 1;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= wrap;
            cnt  <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/key_event_gen.sv
// Turns the debounced key level into press/release/short/long/repeat events timed in ms.
// Auto-repeat in the LONG state is built only when AUTO_REPEAT_EN is defined.
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key,
    output logic              held,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              short_press,
    output logic              long_press,
    output logic              repeat_pulse,
    output logic [HOLD_W-1:0] hold_ms
);

    if (LONG_MS < 2 || REPEAT_MS < 1) begin : g_bad_param
        $error("key_event_gen: LONG_MS must be >= 2 and REPEAT_MS >= 1");
    end

    logic        tick;
    logic        key_q, key_qq;
    logic        rise, fall;
    state_t      state, state_n;
    logic [HOLD_W-1:0] hold_n;
    logic        held_n, press_n, release_n, short_n, long_n;

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_W = (REPEAT_MS > 1) ? $clog2(REPEAT_MS) : 1;
    logic [REP_W-1:0] rep_cnt, rep_n;
    logic             repeat_n;
`endif

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign rise = key_q & ~key_qq;
    assign fall = ~key_q & key_qq;

    // Next-state and next-output logic; a release always beats a same-cycle tick.
    always_comb begin
        state_n   = state;
        hold_n    = hold_ms;
        press_n   = 1'b0;
        release_n = 1'b0;
        short_n   = 1'b0;
        long_n    = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_n     = rep_cnt;
        repeat_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = PRESSED;
                    press_n = 1'b1;
                    hold_n  = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                    short_n   = 1'b1;
                end else if (tick) begin
                    hold_n = sat_inc(hold_ms);
                    if (hold_ms == HOLD_W'(LONG_MS - 1)) begin
                        state_n = LONG;
                        long_n  = 1'b1;
`ifdef AUTO_REPEAT_EN
                        rep_n   = '0;
`endif
                    end
                end
            end
            LONG: begin
                if (fall) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                end else if (tick) begin
                    hold_n = sat_inc(hold_ms);
`ifdef AUTO_REPEAT_EN
                    if (rep_cnt == REP_W'(REPEAT_MS - 1)) begin
                        repeat_n = 1'b1;
                        rep_n    = '0;
                    end else begin
                        rep_n = rep_cnt + REP_W'(1);
                    end
`endif
                end
            end
            default: state_n = IDLE;
        endcase
        held_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q         <= 1'b0;
            key_qq        <= 1'b0;
            state         <= IDLE;
            hold_ms       <= '0;
            held          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            key_q         <= key;
            key_qq        <= key_q;
            state         <= state_n;
            hold_ms       <= hold_n;
            held          <= held_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            short_press   <= short_n;
            long_press    <= long_n;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt      <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            rep_cnt      <= rep_n;
            repeat_pulse <= repeat_n;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule
